// File: rtl/classify_pkg.sv
// Shared constants, FSM state type and one-hot decode helper for the
// classifier scheduler.
package classify_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned CLASS_W     = 4;
    localparam logic [CLASS_W-1:0] ERR_CLASS = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        EMIT
    } state_e;

    // Returns {valid, index}. valid is set only when exactly one bit is set;
    // otherwise the index field carries ERR_CLASS, never a guessed position.
    function automatic logic [CLASS_W:0] onehot_to_idx(input logic [NUM_CLASSES-1:0] onehot);
        logic [CLASS_W-1:0] idx;
        int unsigned        ones;
        idx  = '0;
        ones = 0;
        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            if (onehot[i]) begin
                ones = ones + 1;
                idx  = CLASS_W'(i);
            end
        end
        if (ones == 1) begin
            return {1'b1, idx};
        end
        return {1'b0, ERR_CLASS};
    endfunction

endpackage

// File: rtl/vec_fifo2.sv
// Two-entry synchronous FIFO. Occupancy is registered so full/empty are
// clean flop outputs; a push into a full FIFO or a pop from an empty one
// is ignored.
module vec_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/classify_scheduler.sv
// Sequences the 10-way argmax engine: buffers up to two score vectors,
// launches the engine per vector, waits for done with a timeout, decodes
// the one-hot result and emits it with running statistics.
module classify_scheduler
    import classify_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_vector,
    input  logic [CLASS_W-1:0]                in_label,
    input  logic                              in_check,
    output logic                              eng_start,
    output logic [NUM_CLASSES*DATA_WIDTH-1:0] eng_matrix,
    input  logic [NUM_CLASSES-1:0]            eng_classes,
    input  logic                              eng_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CLASS_W-1:0]                out_class,
    output logic                              out_error,
    output logic                              out_match,
    input  logic                              clear_stats,
    output logic [CNT_WIDTH-1:0]              stat_total,
    output logic [CNT_WIDTH-1:0]              stat_correct,
    output logic [CNT_WIDTH-1:0]              stat_errors,
    output logic                              busy
);

    localparam int unsigned VEC_W   = NUM_CLASSES * DATA_WIDTH;
    localparam int unsigned ENTRY_W = VEC_W + CLASS_W + 1;
    localparam int unsigned TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]     TMR_ONE  = 1;
    localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

    state_e               state_q, state_d;
    logic [VEC_W-1:0]     cur_vec_q, cur_vec_d;
    logic [CLASS_W-1:0]   cur_label_q, cur_label_d;
    logic                 cur_check_q, cur_check_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [CLASS_W-1:0]   out_class_q, out_class_d;
    logic                 out_error_q, out_error_d;
    logic                 out_match_q, out_match_d;
    logic [CNT_WIDTH-1:0] total_q, total_d;
    logic [CNT_WIDTH-1:0] correct_q, correct_d;
    logic [CNT_WIDTH-1:0] errors_q, errors_d;
    logic [CLASS_W:0]     dec;

    logic               fifo_full, fifo_empty, fifo_pop, handshake;
    logic [ENTRY_W-1:0] fifo_rdata;

    vec_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (in_valid && in_ready),
        .wdata_i ({in_vector, in_label, in_check}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready     = !fifo_full;
    assign eng_matrix   = cur_vec_q;
    assign out_class    = out_class_q;
    assign out_error    = out_error_q;
    assign out_match    = out_match_q;
    assign stat_total   = total_q;
    assign stat_correct = correct_q;
    assign stat_errors  = errors_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;
    assign handshake    = (state_q == EMIT) && out_ready;

    // FSM next-state, work-register loads and result decode.
    always_comb begin
        state_d     = state_q;
        cur_vec_d   = cur_vec_q;
        cur_label_d = cur_label_q;
        cur_check_d = cur_check_q;
        timer_d     = timer_q;
        out_class_d = out_class_q;
        out_error_d = out_error_q;
        out_match_d = out_match_q;
        fifo_pop    = 1'b0;
        eng_start   = 1'b0;
        out_valid   = 1'b0;
        dec         = onehot_to_idx(eng_classes);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_vec_d   = fifo_rdata[ENTRY_W-1 -: VEC_W];
                    cur_label_d = fifo_rdata[CLASS_W:1];
                    cur_check_d = fifo_rdata[0];
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                // eng_ready may still be high from the previous item here.
                eng_start = 1'b1;
                timer_d   = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (eng_ready) begin
                    out_class_d = dec[CLASS_W-1:0];
                    out_error_d = !dec[CLASS_W];
                    out_match_d = cur_check_q && dec[CLASS_W] &&
                                  (dec[CLASS_W-1:0] == cur_label_q);
                    state_d     = EMIT;
                end else if (timer_q == TMR_LAST) begin
                    out_class_d = ERR_CLASS;
                    out_error_d = 1'b1;
                    out_match_d = 1'b0;
                    state_d     = EMIT;
                end else begin
                    timer_d = timer_q + TMR_ONE;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_comb begin
        total_d   = total_q;
        correct_d = correct_q;
        errors_d  = errors_q;
        if (clear_stats) begin
            total_d   = '0;
            correct_d = '0;
            errors_d  = '0;
        end else if (handshake) begin
            if (!(&total_q)) begin
                total_d = total_q + CNT_ONE;
            end
            if (out_match_q && !(&correct_q)) begin
                correct_d = correct_q + CNT_ONE;
            end
            if (out_error_q && !(&errors_q)) begin
                errors_d = errors_q + CNT_ONE;
            end
        end
    end

    // State, work, result and statistics registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_vec_q   <= '0;
            cur_label_q <= '0;
            cur_check_q <= 1'b0;
            timer_q     <= '0;
            out_class_q <= '0;
            out_error_q <= 1'b0;
            out_match_q <= 1'b0;
            total_q     <= '0;
            correct_q   <= '0;
            errors_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_vec_q   <= cur_vec_d;
            cur_label_q <= cur_label_d;
            cur_check_q <= cur_check_d;
            timer_q     <= timer_d;
            out_class_q <= out_class_d;
            out_error_q <= out_error_d;
            out_match_q <= out_match_d;
            total_q     <= total_d;
            correct_q   <= correct_d;
            errors_q    <= errors_d;
        end
    end

endmodule

// File: tb/tb_classify_scheduler.sv
// Directed bench for classify_scheduler with a sticky-ready engine model,
// an expected-result queue and a saturating statistics model.
module tb_classify_scheduler;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int CW = 3;

    typedef struct {
        logic [3:0] cls;
        logic       err;
        logic       match;
        int         span;
    } exp_t;

    typedef struct {
        logic [9:0] classes;
        int         lat;
    } resp_t;

    logic          clk, reset_n;
    logic          in_valid, in_ready, in_check;
    logic [79:0]   in_vector;
    logic [3:0]    in_label;
    logic          eng_start, eng_ready;
    logic [79:0]   eng_matrix;
    logic [9:0]    eng_classes;
    logic          out_valid, out_ready, out_error, out_match;
    logic [3:0]    out_class;
    logic          clear_stats, busy;
    logic [CW-1:0] stat_total, stat_correct, stat_errors;

    exp_t        exp_q[$];
    resp_t       resp_q[$];
    logic [79:0] mat_q[$];
    int          hs_cyc[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          starts = 0;
    int          last_start = 0;
    int          m_total = 0, m_correct = 0, m_errors = 0;
    int          maxc = (1 << CW) - 1;

    classify_scheduler #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_vector    (in_vector),
        .in_label     (in_label),
        .in_check     (in_check),
        .eng_start    (eng_start),
        .eng_matrix   (eng_matrix),
        .eng_classes  (eng_classes),
        .eng_ready    (eng_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_class    (out_class),
        .out_error    (out_error),
        .out_match    (out_match),
        .clear_stats  (clear_stats),
        .stat_total   (stat_total),
        .stat_correct (stat_correct),
        .stat_errors  (stat_errors),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [9:0] c, input int lat, input logic [3:0] lbl,
                                   input logic chk, input int span);
        exp_t e;
        int   ones = 0;
        int   idx = 0;
        for (int i = 0; i < 10; i++) begin
            if (c[i]) begin
                ones++;
                idx = i;
            end
        end
        e.span = span;
        if (lat == 0 || ones != 1) begin
            e.cls = 4'hF; e.err = 1'b1; e.match = 1'b0;
        end else begin
            e.cls = 4'(idx); e.err = 1'b0; e.match = chk && (4'(idx) == lbl);
        end
        return e;
    endfunction

    // Engine model: ready is sticky until the next start, fires lat edges after it.
    initial begin
        logic       start_seen, busy_m;
        int         lat;
        logic [9:0] pend;
        resp_t      r;
        eng_ready = 1'b0; eng_classes = '0;
        start_seen = 1'b0; busy_m = 1'b0; lat = 0; pend = '0;
        forever begin
            @(posedge clk); #2;
            if (!reset_n) begin
                eng_ready = 1'b0; busy_m = 1'b0; start_seen = 1'b0;
            end else begin
                if (start_seen) begin
                    eng_ready = 1'b0; busy_m = 1'b0;
                    if (resp_q.size() > 0) begin
                        r = resp_q.pop_front();
                        if (r.lat > 0) begin
                            busy_m = 1'b1; lat = r.lat; pend = r.classes;
                        end
                    end
                end else if (busy_m) begin
                    if (lat == 1) begin
                        eng_ready = 1'b1; eng_classes = pend; busy_m = 1'b0;
                    end else begin
                        lat--;
                    end
                end
                start_seen = eng_start;
            end
        end
    end

    // Output monitor: scoreboard pop on handshake, launch tracking, stats model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                starts++;
                last_start = cyc;
                check("start_has_item", 80'(mat_q.size() != 0), 80'd1);
                if (mat_q.size() != 0) check("eng_matrix", eng_matrix, mat_q.pop_front());
            end
            if (out_valid && out_ready) begin
                hs_cyc.push_back(cyc);
                check("result_has_item", 80'(exp_q.size() != 0), 80'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_class", out_class, e.cls);
                    check("out_error", out_error, e.err);
                    check("out_match", out_match, e.match);
                    if (e.span > 0) check("latency", cyc - last_start, e.span);
                    if (!clear_stats) begin
                        if (m_total < maxc) m_total++;
                        if (e.match && m_correct < maxc) m_correct++;
                        if (e.err && m_errors < maxc) m_errors++;
                    end
                end
            end
            if (clear_stats) begin
                m_total = 0; m_correct = 0; m_errors = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [79:0] v, input logic [3:0] lbl, input logic chk,
                        input logic [9:0] classes, input int lat, input int span);
        int    guard = 0;
        resp_t r;
        in_valid = 1'b1; in_vector = v; in_label = lbl; in_check = chk;
        while (!in_ready && guard < 200) begin
            tick(1);
            guard++;
        end
        if (guard >= 200) check("in_ready_wait", in_ready, 1'b1);
        r.classes = classes; r.lat = lat;
        resp_q.push_back(r);
        exp_q.push_back(model(classes, lat, lbl, chk, span));
        mat_q.push_back(v);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 400) begin
            tick(1);
            guard++;
        end
        if (guard >= 400) check("idle_wait", busy, 1'b0);
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_total"}, stat_total, m_total);
        check({tag, "_correct"}, stat_correct, m_correct);
        check({tag, "_errors"}, stat_errors, m_errors);
    endtask

    function automatic logic [79:0] rand_vec();
        logic [79:0] v;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    initial begin
        logic [79:0] v1, vh;
        int          lanes1[10] = '{3, -1, 7, 0, 2, 9, -5, 1, 4, 6};
        int          s0, h0, guard;

        reset_n = 1'b0; in_valid = 1'b0; in_vector = '0; in_label = '0; in_check = 1'b0;
        out_ready = 1'b1; clear_stats = 1'b0;
        tick(3);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_class", out_class, 4'h0);
        check("rst_out_error", out_error, 1'b0);
        check("rst_out_match", out_match, 1'b0);
        check("rst_eng_start", eng_start, 1'b0);
        check("rst_eng_matrix", eng_matrix, 80'd0);
        check("rst_busy", busy, 1'b0);
        check_stats("rst");
        reset_n = 1'b1;
        tick(1);
        check("rst_in_ready", in_ready, 1'b1);

        // Nominal classification with lane 0 in the MSB slice.
        for (int i = 0; i < 10; i++) v1[(9-i)*8 +: 8] = 8'(lanes1[i]);
        send(v1, 4'd5, 1'b1, 10'b0000100000, 3, 5);
        wait_idle();
        check("t1_total", stat_total, 3'd1);
        check("t1_correct", stat_correct, 3'd1);
        check_stats("t1");

        // Three back-to-back vectors.
        s0 = starts; h0 = hs_cyc.size();
        send(rand_vec(), 4'd0, 1'b1, 10'b0000000001, 3, 5);
        send(rand_vec(), 4'd9, 1'b0, 10'b1000000000, 3, 5);
        send(rand_vec(), 4'd4, 1'b1, 10'b0000001000, 3, 5);
        check("b2b_in_ready_full", in_ready, 1'b0);
        wait_idle();
        check("b2b_starts", starts - s0, 3);
        check("b2b_results", hs_cyc.size() - h0, 3);
        if (hs_cyc.size() >= h0 + 3) begin
            check("b2b_spacing1", hs_cyc[h0+1] - hs_cyc[h0], 7);
            check("b2b_spacing2", hs_cyc[h0+2] - hs_cyc[h0+1], 7);
        end
        check("b2b_in_ready", in_ready, 1'b1);
        check_stats("b2b");

        // Hung engine, then a normal vector behind it.
        send(rand_vec(), 4'd3, 1'b1, 10'b0000001000, 0, TO + 1);
        send(rand_vec(), 4'd2, 1'b1, 10'b0000000100, 3, 5);
        wait_idle();
        check("to_errors", stat_errors, 3'd1);
        check_stats("to");

        // Multi-hot result.
        send(rand_vec(), 4'd5, 1'b1, 10'b0000100001, 3, 5);
        wait_idle();
        check_stats("multi");

        // Stale ready (multi-hot classes still presented) during LAUNCH.
        send(rand_vec(), 4'd1, 1'b1, 10'b0000000010, 3, 5);
        wait_idle();
        check("sat_total", stat_total, 3'd7);
        check_stats("stale");

        // Backpressure hold, then clear on the handshake cycle.
        out_ready = 1'b0;
        vh = rand_vec();
        send(vh, 4'd8, 1'b1, 10'b0100000000, 3, 0);
        guard = 0;
        while (!out_valid && guard < 100) begin
            tick(1);
            guard++;
        end
        check("hold_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("hold_outputs", {out_valid, out_class, out_error, out_match}, {1'b1, 4'd8, 1'b0, 1'b1});
            check("hold_matrix", eng_matrix, vh);
            tick(1);
        end
        out_ready = 1'b1; clear_stats = 1'b1;
        tick(1);
        clear_stats = 1'b0;
        check("clr_out_valid", out_valid, 1'b0);
        check("clr_total", stat_total, 3'd0);
        check("clr_correct", stat_correct, 3'd0);
        check("clr_errors", stat_errors, 3'd0);
        check_stats("clr");

        // Reset while waiting on the engine.
        send(rand_vec(), 4'd4, 1'b1, 10'b0000010000, 3, 5);
        guard = 0;
        while (!eng_start && guard < 50) begin
            tick(1);
            guard++;
        end
        check("rw_launch_seen", eng_start, 1'b1);
        tick(2);
        check("rw_busy_in_wait", busy, 1'b1);
        reset_n = 1'b0;
        tick(1);
        exp_q.delete(); resp_q.delete(); mat_q.delete();
        m_total = 0; m_correct = 0; m_errors = 0;
        check("rw_out_valid", out_valid, 1'b0);
        check("rw_busy", busy, 1'b0);
        check("rw_in_ready", in_ready, 1'b1);
        check("rw_eng_matrix", eng_matrix, 80'd0);
        reset_n = 1'b1;
        tick(3);
        check("rw_after_valid", out_valid, 1'b0);
        check_stats("rw");
        send(rand_vec(), 4'd4, 1'b1, 10'b0000010000, 3, 5);
        wait_idle();
        check("rec_total", stat_total, 3'd1);
        check("rec_correct", stat_correct, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
